// File: rtl/can_dispense_ctrl_pkg.sv
// Shared types and widths for the can dispense sequencer/arbiter.
package can_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DISP = 2'd2,
        GAP  = 2'd3
    } can_state_t;

    localparam int CAN_CW    = 8;
    localparam int CAN_TOT_W = 16;

endpackage

// File: rtl/can_dispense_ctrl_if.sv
// Requester, refill and dispense-counter signals shared by the controller and its environment.
interface can_dispense_ctrl_if
    import can_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int CW   = CAN_CW
);
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      ack;
    logic                 refill_req;
    logic [CW-1:0]        refill_val;
    logic                 stock_avail;
    logic                 ctr_load;
    logic [CW-1:0]        ctr_count;
    logic                 ctr_dispense;
    logic                 busy;
    logic                 sold_out;
    logic [CAN_TOT_W-1:0] disp_total;

    // master is the controller; slave is the requesters, operator panel and counter
    modport master (
        input  req, refill_req, refill_val, stock_avail,
        output ack, ctr_load, ctr_count, ctr_dispense, busy, sold_out, disp_total
    );

    modport slave (
        output req, refill_req, refill_val, stock_avail,
        input  ack, ctr_load, ctr_count, ctr_dispense, busy, sold_out, disp_total
    );
endinterface

// File: rtl/can_dispense_ctrl_arb.sv
// Combinational round-robin pick: first set request at or above rr_ptr, wrapping.
module can_rr_arb #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            grant_vld
);

    always_comb begin
        int k;
        k         = 0;
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            k = (int'(rr_ptr) + i) % NREQ;
            if (!grant_vld && req[k]) begin
                grant_vld = 1'b1;
                grant_idx = IW'(k);
                grant[k]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/can_dispense_ctrl.sv
// Shares one dispense counter between NREQ requesters, serialising refills against dispenses.
module can_dispense_ctrl
    import can_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int CW      = CAN_CW,
    parameter int GAP_CYC = 2
) (
    input logic                clk,
    input logic                rst_n,
    can_dispense_ctrl_if.master bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    can_state_t           state, state_nxt;
    logic [3:0]           gap_cnt;
    logic [IW-1:0]        rr_ptr;
    logic                 refill_pend;
    logic                 set_sold;
    logic                 enter_load, enter_disp, enter_gap;

    logic [NREQ-1:0]      grant;
    logic [IW-1:0]        grant_idx;
    logic                 grant_vld;
    logic [IW-1:0]        rr_nxt;

    logic [NREQ-1:0]      ack_r;
    logic                 load_r;
    logic                 disp_r;
    logic                 busy_r;
    logic                 sold_r;
    logic [CW-1:0]        count_r;
    logic [CAN_TOT_W-1:0] total_r;

    function automatic logic [CAN_TOT_W-1:0] sat_inc(input logic [CAN_TOT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    can_rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req       (bus.req),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    assign rr_nxt = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

    // A refill arriving in the very IDLE cycle already counts, so it beats a same-cycle request.
    always_comb begin
        state_nxt = state;
        set_sold  = 1'b0;
        case (state)
            IDLE: begin
                if (refill_pend || bus.refill_req)
                    state_nxt = LOAD;
                else if (grant_vld && bus.stock_avail)
                    state_nxt = DISP;
                else if (grant_vld)
                    set_sold = 1'b1;
            end
            LOAD:    state_nxt = GAP;
            DISP:    state_nxt = GAP;
            GAP:     if (gap_cnt == 4'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign enter_load = (state == IDLE) && (state_nxt == LOAD);
    assign enter_disp = (state == IDLE) && (state_nxt == DISP);
    assign enter_gap  = (state != GAP)  && (state_nxt == GAP);

    // Outputs are registered from the next-state decision so they line up with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gap_cnt     <= '0;
            rr_ptr      <= '0;
            refill_pend <= 1'b0;
            ack_r       <= '0;
            load_r      <= 1'b0;
            disp_r      <= 1'b0;
            busy_r      <= 1'b0;
            sold_r      <= 1'b0;
            count_r     <= '0;
            total_r     <= '0;
        end else begin
            state  <= state_nxt;
            load_r <= enter_load;
            disp_r <= enter_disp;
            ack_r  <= enter_disp ? grant : '0;
            busy_r <= (state_nxt != IDLE);

            if (enter_gap)
                gap_cnt <= 4'(GAP_CYC - 1);
            else if ((state == GAP) && (gap_cnt != 4'd0))
                gap_cnt <= gap_cnt - 4'd1;

            if (enter_load)
                refill_pend <= 1'b0;
            else if (bus.refill_req)
                refill_pend <= 1'b1;

            if (bus.refill_req)
                count_r <= bus.refill_val;

            if (enter_load)
                sold_r <= 1'b0;
            else if (set_sold)
                sold_r <= 1'b1;

            if (enter_disp) begin
                rr_ptr  <= rr_nxt;
                total_r <= sat_inc(total_r);
            end
        end
    end

    assign bus.ack          = ack_r;
    assign bus.ctr_load     = load_r;
    assign bus.ctr_count    = count_r;
    assign bus.ctr_dispense = disp_r;
    assign bus.busy         = busy_r;
    assign bus.sold_out     = sold_r;
    assign bus.disp_total   = total_r;

endmodule

// File: tb/tb_can_dispense_ctrl.sv
// Directed bench for can_dispense_ctrl: expected counter events are queued, a monitor pops and compares.
module tb_can_dispense_ctrl;
    import can_pkg::*;

    localparam int NREQ = 4;
    localparam int CW   = 8;
    localparam int GAPC = 2;
    localparam int SP   = GAPC + 2;

    typedef struct {
        bit          is_load;
        int          idx;
        logic [7:0]  cnt;
        int          sp;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;
    exp_t q[$];

    can_dispense_ctrl_if #(.NREQ(NREQ), .CW(CW)) bus ();

    can_dispense_ctrl #(.NREQ(NREQ), .CW(CW), .GAP_CYC(GAPC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req_v, cyc);
        end
    endtask

    task automatic push_load(input logic [7:0] cnt);
        exp_t e;
        e.is_load = 1'b1; e.idx = 0; e.cnt = cnt; e.sp = 0;
        q.push_back(e);
    endtask

    task automatic push_disp(input int idx, input int sp);
        exp_t e;
        e.is_load = 1'b0; e.idx = idx; e.cnt = '0; e.sp = sp;
        q.push_back(e);
    endtask

    task automatic wait_acks(input int n);
        int got;
        int budget;
        got = 0;
        budget = 40 * n;
        while (got < n && budget > 0) begin
            @(negedge clk);
            budget--;
            if (bus.ack != '0) got++;
        end
        if (got < n) begin
            errors++;
            checks++;
            $display("FAIL ack_timeout actual=%0d required=%0d", got, n);
        end
    endtask

    task automatic wait_idle();
        int budget;
        budget = 40;
        do begin
            @(negedge clk);
            budget--;
        end while (bus.busy && budget > 0);
        if (bus.busy) begin
            errors++;
            checks++;
            $display("FAIL idle_timeout actual=busy required=idle");
        end
    endtask

    // Monitor: every counter strobe or ack must match the next queued expectation.
    initial begin
        exp_t e;
        int   last_evt;
        int   stock;
        last_evt = 0;
        stock = 0;
        bus.stock_avail = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.ctr_load || bus.ctr_dispense || (bus.ack != '0)) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_event actual=load%b/disp%b/ack%b required=none",
                                 bus.ctr_load, bus.ctr_dispense, bus.ack);
                    end else begin
                        e = q.pop_front();
                        chk("strobes_exclusive", 32'(bus.ctr_load & bus.ctr_dispense), 0);
                        if (e.is_load) begin
                            chk("load_strobe", 32'(bus.ctr_load), 1);
                            chk("load_count", 32'(bus.ctr_count), 32'(e.cnt));
                            chk("load_ack", 32'(bus.ack), 0);
                            chk("load_sold_out", 32'(bus.sold_out), 0);
                        end else begin
                            chk("disp_strobe", 32'(bus.ctr_dispense), 1);
                            chk("disp_ack", 32'(bus.ack), 32'(1) << e.idx);
                        end
                        if (e.sp != 0) chk("event_spacing", 32'(cyc - last_evt), 32'(e.sp));
                    end
                    last_evt = cyc;
                end
                if (bus.ctr_load) stock = int'(bus.ctr_count);
                if (bus.ctr_dispense && stock != 0) stock--;
                bus.stock_avail = (stock != 0);
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        rst_n = 1'b0;
        bus.req = '0;
        bus.refill_req = 1'b0;
        bus.refill_val = '0;
        repeat (3) @(negedge clk);

        chk("rst_ack", 32'(bus.ack), 0);
        chk("rst_load", 32'(bus.ctr_load), 0);
        chk("rst_count", 32'(bus.ctr_count), 0);
        chk("rst_disp", 32'(bus.ctr_dispense), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_sold_out", 32'(bus.sold_out), 0);
        chk("rst_total", 32'(bus.disp_total), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // All four requesting: round-robin order 0,1,2,3,0, then 0101 picks 2
        push_load(8'd200);
        push_disp(0, SP); push_disp(1, SP); push_disp(2, SP); push_disp(3, SP); push_disp(0, SP);
        push_disp(2, SP);
        bus.refill_req = 1'b1; bus.refill_val = 8'd200; bus.req = 4'b1111;
        @(negedge clk);
        bus.refill_req = 1'b0;
        wait_acks(5);
        bus.req = 4'b0101;
        wait_acks(1);
        bus.req = '0;
        wait_idle();
        chk("total_after_rr", 32'(bus.disp_total), 6);

        // Refill of 3 then a single requester drains it
        push_load(8'd3);
        push_disp(0, SP); push_disp(0, SP); push_disp(0, SP);
        bus.refill_req = 1'b1; bus.refill_val = 8'd3;
        @(negedge clk);
        bus.refill_req = 1'b0; bus.req = 4'b0001;
        wait_acks(3);
        bus.req = '0;
        wait_idle();
        chk("total_after_drain", 32'(bus.disp_total), 9);

        // Empty counter: sold_out, no ack; a refill clears it and serves the waiting requester
        bus.req = 4'b0010;
        repeat (3) @(negedge clk);
        chk("sold_out_set", 32'(bus.sold_out), 1);
        chk("sold_out_no_ack", 32'(bus.ack), 0);
        chk("sold_out_idle", 32'(bus.busy), 0);
        push_load(8'd5);
        push_disp(1, SP);
        bus.refill_req = 1'b1; bus.refill_val = 8'd5;
        @(negedge clk);
        bus.refill_req = 1'b0;
        wait_acks(1);
        bus.req = '0;
        wait_idle();

        // Refill and request in the same IDLE cycle: load wins
        push_load(8'd7);
        push_disp(2, SP);
        bus.refill_req = 1'b1; bus.refill_val = 8'd7; bus.req = 4'b0100;
        @(negedge clk);
        bus.refill_req = 1'b0;
        wait_acks(1);
        bus.req = '0;
        wait_idle();

        // One-cycle latency from request seen in IDLE to dispense
        push_disp(3, 0);
        bus.req = 4'b1000;
        @(negedge clk);
        chk("latency_disp", 32'(bus.ctr_dispense), 1);
        chk("latency_ack", 32'(bus.ack), 32'h8);
        bus.req = '0;
        wait_idle();
        chk("total_before_rst", 32'(bus.disp_total), 12);

        // Asynchronous reset in the middle of a dispense
        bus.req = 4'b0001;
        @(posedge clk);
        #2;
        chk("pre_rst_disp", 32'(bus.ctr_dispense), 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_disp", 32'(bus.ctr_dispense), 0);
        chk("async_rst_ack", 32'(bus.ack), 0);
        chk("async_rst_busy", 32'(bus.busy), 0);
        chk("async_rst_total", 32'(bus.disp_total), 0);
        chk("async_rst_count", 32'(bus.ctr_count), 0);
        chk("async_rst_fsm", 32'(dut.state), 32'(IDLE));
        @(negedge clk);
        bus.req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 32'(bus.busy), 0);

        // Saturation of the dispense total
        force dut.total_r = 16'hFFFE;
        @(negedge clk);
        release dut.total_r;
        chk("total_preload", 32'(bus.disp_total), 32'hFFFE);
        push_disp(0, 0); push_disp(0, SP);
        bus.req = 4'b0001;
        wait_acks(1);
        chk("total_reach_max", 32'(bus.disp_total), 32'hFFFF);
        wait_acks(1);
        chk("total_saturate", 32'(bus.disp_total), 32'hFFFF);
        bus.req = '0;
        wait_idle();
        repeat (2) @(negedge clk);

        chk("scoreboard_drained", 32'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
